// File: rtl/sifive_reset_pkg.sv
// Shared encodings for the staged reset sequencer: FSM states and reset-cause codes.
package sifive_reset_pkg;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;

endpackage

// File: rtl/sifive_reset_sync_chain.sv
// Multi-flop synchroniser for an asynchronous level; resets to 1 so the request reads as active.
module sifive_reset_sync_chain #(
    parameter int unsigned STAGES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/sifive_reset_sequencer.sv
// Staged reset sequencer: debounce hold, ordered per-stage release, cause and event tracking.
// Define RESET_SEQ_ORDERED_ASSERT_EN to re-assert stages top-down (DRAIN) on a request in RUN.
module sifive_reset_sequencer
    import sifive_reset_pkg::*;
#(
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned HOLD_BITS   = 8,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned COUNT_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               areq,
    input  logic               sw_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               ready,
    output logic [1:0]         last_cause,
    output logic [COUNT_W-1:0] rst_count
);

    localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic                 areq_s;
    logic                 req;
    logic [1:0]           state, state_nxt;
    logic [HOLD_BITS-1:0] hold_cnt, hold_nxt;
    logic [GAP_W-1:0]     gap_cnt, gap_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [NUM_OUT-1:0]   rst_nxt;
    logic                 ready_nxt;
    logic [1:0]           cause_nxt;
    logic [COUNT_W-1:0]   count_nxt;
    logic [1:0]           req_cause;
    logic [COUNT_W-1:0]   count_inc;

    sifive_reset_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_areq_sync (
        .clock (clock),
        .reset (reset),
        .d     (areq),
        .q     (areq_s)
    );

    assign req       = areq_s | sw_req;
    assign req_cause = sw_req ? (areq_s ? CAUSE_BOTH : CAUSE_SW) : CAUSE_EXT;
    assign count_inc = (rst_count == '1) ? rst_count : rst_count + COUNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_HOLD;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            idx        <= '0;
            rst_out    <= '1;
            ready      <= 1'b0;
            last_cause <= CAUSE_POR;
            rst_count  <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            gap_cnt    <= gap_nxt;
            idx        <= idx_nxt;
            rst_out    <= rst_nxt;
            ready      <= ready_nxt;
            last_cause <= cause_nxt;
            rst_count  <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        gap_nxt   = gap_cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_out;
        ready_nxt = ready;
        cause_nxt = last_cause;
        count_nxt = rst_count;

        case (state)
            ST_HOLD: begin
                if (req) begin
                    hold_nxt = '0;
                end else if (hold_cnt == '1) begin
                    rst_nxt[0] = 1'b0;
                    idx_nxt    = IDX_W'(1);
                    gap_nxt    = '0;
                    hold_nxt   = '0;
                    if (NUM_OUT == 1) begin
                        ready_nxt = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt = ST_RELEASE;
                    end
                end else begin
                    hold_nxt = hold_cnt + HOLD_BITS'(1);
                end
            end

            ST_RELEASE: begin
                if (req) begin
                    rst_nxt   = '1;
                    ready_nxt = 1'b0;
                    hold_nxt  = '0;
                    cause_nxt = req_cause;
                    count_nxt = count_inc;
                    state_nxt = ST_HOLD;
                end else if (gap_cnt == GAP_LAST) begin
                    rst_nxt[idx] = 1'b0;
                    gap_nxt      = '0;
                    if (idx == LAST_IDX) begin
                        ready_nxt = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end

            ST_RUN: begin
                if (req) begin
                    ready_nxt = 1'b0;
                    hold_nxt  = '0;
                    gap_nxt   = '0;
                    cause_nxt = req_cause;
                    count_nxt = count_inc;
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
                    if (NUM_OUT == 1) begin
                        rst_nxt   = '1;
                        state_nxt = ST_HOLD;
                    end else begin
                        rst_nxt[NUM_OUT-1] = 1'b1;
                        idx_nxt            = LAST_IDX;
                        state_nxt          = ST_DRAIN;
                    end
`else
                    rst_nxt   = '1;
                    state_nxt = ST_HOLD;
`endif
                end
            end

            ST_DRAIN: begin
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
                // Walk assertion downward one stage per gap; requests here are ignored.
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt                    = '0;
                    rst_nxt[idx - IDX_W'(1)]   = 1'b1;
                    idx_nxt                    = idx - IDX_W'(1);
                    if (idx == IDX_W'(1)) begin
                        hold_nxt  = '0;
                        state_nxt = ST_HOLD;
                    end
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
`else
                rst_nxt   = '1;
                ready_nxt = 1'b0;
                hold_nxt  = '0;
                state_nxt = ST_HOLD;
`endif
            end

            default: begin
                state_nxt = ST_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_sifive_reset_sequencer.sv
// Directed bench for sifive_reset_sequencer (NUM_OUT=4, SYNC_STAGES=3, HOLD_BITS=4, GAP_CYCLES=4).
module tb_sifive_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       areq = 1'b0;
    logic       sw_req = 1'b0;
    logic [3:0] rst_out;
    logic       ready;
    logic [1:0] last_cause;
    logic [7:0] rst_count;

    int total = 0;
    int bad = 0;
    int e = -1;
    int k;
    int a;

    sifive_reset_sequencer #(
        .NUM_OUT     (4),
        .SYNC_STAGES (3),
        .HOLD_BITS   (4),
        .GAP_CYCLES  (4),
        .COUNT_W     (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .areq       (areq),
        .sw_req     (sw_req),
        .rst_out    (rst_out),
        .ready      (ready),
        .last_cause (last_cause),
        .rst_count  (rst_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got=%0h want=%0h", tag, e, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        e++;
    endtask

    task automatic run_to(input int target);
        while (e < target) tick();
    endtask

    // Reset is released just after an edge, so the next edge is edge 0.
    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        areq = 1'b0;
        sw_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        e = -1;
    endtask

    task automatic pulse_sw();
        sw_req = 1'b1;
        tick();
        sw_req = 1'b0;
    endtask

    task automatic wait_bit(input int bitn, input int limit, input string tag);
        int n = 0;
        while (rst_out[bitn] !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(rst_out[bitn]), 32'd0);
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (ready !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("wait_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_out_por", 32'(rst_out), 32'hF);
        check("ready_por", 32'(ready), 32'd0);
        check("cause_por", 32'(last_cause), 32'd0);
        check("count_por", 32'(rst_count), 32'd0);

        // Power-on sequence: stage releases at edges 18, 22, 26, 30
        run_to(17); check("s1_pre0", 32'(rst_out), 32'hF);
        run_to(18); check("s1_rel0", 32'(rst_out), 32'hE);
        run_to(21); check("s1_pre1", 32'(rst_out), 32'hE);
        run_to(22); check("s1_rel1", 32'(rst_out), 32'hC);
        run_to(26); check("s1_rel2", 32'(rst_out), 32'h8);
        run_to(29); check("s1_pre3", 32'(rst_out), 32'h8);
        check("s1_nready", 32'(ready), 32'd0);
        run_to(30); check("s1_rel3", 32'(rst_out), 32'h0);
        check("s1_ready", 32'(ready), 32'd1);
        check("s1_cause", 32'(last_cause), 32'd0);
        check("s1_count", 32'(rst_count), 32'd0);

        // Software request in RUN at edge k
        k = e + 1;
        pulse_sw();
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
        check("s5_k", 32'(rst_out), 32'h8);
        check("s5_nready", 32'(ready), 32'd0);
        check("s5_cause", 32'(last_cause), 32'd2);
        check("s5_count", 32'(rst_count), 32'd1);
        run_to(k + 3);  check("s5_k3", 32'(rst_out), 32'h8);
        run_to(k + 4);  check("s5_k4", 32'(rst_out), 32'hC);
        run_to(k + 8);  check("s5_k8", 32'(rst_out), 32'hE);
        run_to(k + 11); check("s5_k11", 32'(rst_out), 32'hE);
        run_to(k + 12); check("s5_k12", 32'(rst_out), 32'hF);
        run_to(k + 27); check("s5_k27", 32'(rst_out), 32'hF);
        run_to(k + 28); check("s5_k28", 32'(rst_out), 32'hE);
        run_to(k + 40); check("s5_k40", 32'(rst_out), 32'h0);
        check("s5_ready", 32'(ready), 32'd1);
`else
        check("s3_k", 32'(rst_out), 32'hF);
        check("s3_nready", 32'(ready), 32'd0);
        check("s3_cause", 32'(last_cause), 32'd2);
        check("s3_count", 32'(rst_count), 32'd1);
        run_to(k + 15); check("s3_k15", 32'(rst_out), 32'hF);
        run_to(k + 16); check("s3_k16", 32'(rst_out), 32'hE);
        run_to(k + 20); check("s3_k20", 32'(rst_out), 32'hC);
        run_to(k + 28); check("s3_k28", 32'(rst_out), 32'h0);
        check("s3_ready", 32'(ready), 32'd1);
        run_to(k + 40); check("s3_k40", 32'(rst_out), 32'h0);
`endif

        // areq in RELEASE after stage 1 released: all stages back three edges after first sample
        pulse_sw();
        check("s4_count_a", 32'(rst_count), 32'd2);
        wait_bit(1, 80, "s4_wait1");
        areq = 1'b1;
        a = e + 1;
        run_to(a + 2); check("s4_a2", 32'(rst_out), 32'hC);
        run_to(a + 3); check("s4_a3", 32'(rst_out), 32'hF);
        check("s4_nready", 32'(ready), 32'd0);
        check("s4_cause", 32'(last_cause), 32'd1);
        check("s4_count", 32'(rst_count), 32'd3);
        areq = 1'b0;

        // areq pulse in HOLD at hold count 10 delays first release by 14 cycles
        do_reset();
        run_to(12);
        areq = 1'b1;
        tick();
        areq = 1'b0;
        run_to(31); check("s2_pre", 32'(rst_out), 32'hF);
        check("s2_cause", 32'(last_cause), 32'd0);
        check("s2_count", 32'(rst_count), 32'd0);
        run_to(32); check("s2_rel0", 32'(rst_out), 32'hE);

        // Count saturation, then block reset from RUN
        for (int i = 0; i < 256; i++) begin
            pulse_sw();
            if (i == 254) check("s6_count255", 32'(rst_count), 32'd255);
            wait_bit(0, 64, "s6_rel0");
        end
        check("s6_sat", 32'(rst_count), 32'd255);
        check("s6_cause", 32'(last_cause), 32'd2);
        wait_ready(64);
        do_reset();
        check("s6_rst_out", 32'(rst_out), 32'hF);
        check("s6_rst_ready", 32'(ready), 32'd0);
        check("s6_rst_cause", 32'(last_cause), 32'd0);
        check("s6_rst_count", 32'(rst_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
